// File: rtl/mux_l1_rr.sv
// Four-lane L1 serializer: per-lane byte FIFOs drained one byte per cycle
// through a round-robin arbiter into a registered byte stream.
module mux_l1_rr #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] L1_in0,
  input  logic [7:0] L1_in1,
  input  logic [7:0] L1_in2,
  input  logic [7:0] L1_in3,
  input  logic       L1_valid0,
  input  logic       L1_valid1,
  input  logic       L1_valid2,
  input  logic       L1_valid3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic [1:0] lane_out,
  output logic [3:0] fifo_full,
  output logic [3:0] overflow,
  output logic       idle
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [3:0][7:0]    din;
  logic [3:0]         vin;
  logic [7:0]         mem_q [4][FIFO_DEPTH];
  logic [3:0][PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0][PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         rr_q, rr_d;
  logic [1:0]         cand;
  logic               gnt_vld;
  logic [1:0]         gnt_lane;
  logic [3:0]         pop;
  logic [3:0]         wr_en;
  logic [7:0]         data_d;
  logic               valid_d;
  logic [1:0]         lane_d;
  logic [3:0]         ovf_d;
  logic               idle_d;

  assign din = {L1_in3, L1_in2, L1_in1, L1_in0};
  assign vin = {L1_valid3, L1_valid2, L1_valid1, L1_valid0};

  // Arbitration looks only at pre-edge counts, so a byte written this edge
  // cannot be granted until the next one.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_lane = rr_q;
    cand     = rr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_q + 2'(i);
      if (!gnt_vld && cnt_q[cand] != '0) begin
        gnt_vld  = 1'b1;
        gnt_lane = cand;
      end
    end
  end

  assign pop = gnt_vld ? (4'b0001 << gnt_lane) : 4'b0000;

  always_comb begin
    wr_en    = '0;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int l = 0; l < 4; l++) begin
      // A full lane still takes a write when it is being popped the same edge.
      wr_en[l]    = vin[l] && ((cnt_q[l] != DEPTH_C) || pop[l]);
      cnt_d[l]    = cnt_q[l] + CW'(wr_en[l]) - CW'(pop[l]);
      wr_ptr_d[l] = wr_ptr_q[l] + PW'(wr_en[l]);
      rd_ptr_d[l] = rd_ptr_q[l] + PW'(pop[l]);
    end
  end

  always_comb begin
    for (int l = 0; l < 4; l++) begin
      fifo_full[l] = (cnt_q[l] == DEPTH_C);
    end
  end

  always_comb begin
    data_d  = data_out;
    lane_d  = lane_out;
    valid_d = gnt_vld;
    rr_d    = rr_q;
    if (gnt_vld) begin
      data_d = mem_q[gnt_lane][rd_ptr_q[gnt_lane]];
      lane_d = gnt_lane;
      rr_d   = gnt_lane + 2'd1;
    end
    ovf_d  = overflow | (vin & ~wr_en);
    idle_d = (cnt_d == '0) && (vin == 4'b0000);
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (wr_en[l]) begin
        mem_q[l][wr_ptr_q[l]] <= din[l];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rr_q      <= 2'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      lane_out  <= 2'd0;
      overflow  <= 4'b0000;
      idle      <= 1'b1;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      data_out  <= data_d;
      valid_out <= valid_d;
      lane_out  <= lane_d;
      overflow  <= ovf_d;
      idle      <= idle_d;
    end
  end

endmodule

// File: tb/tb_mux_l1_rr.sv
// Bench for mux_l1_rr: directed scenarios plus random traffic, all compared
// against a queue-based model of the lane FIFOs and round-robin arbiter.
module tb_mux_l1_rr;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic [7:0] L1_in0, L1_in1, L1_in2, L1_in3;
  logic       L1_valid0, L1_valid1, L1_valid2, L1_valid3;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_out;
  logic [3:0] fifo_full;
  logic [3:0] overflow;
  logic       idle;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq [4][$];
  int         rr_m;
  logic [7:0] e_data;
  logic       e_valid;
  logic [1:0] e_lane;
  logic [3:0] e_ovf;
  logic       e_idle;

  mux_l1_rr #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset_L(reset_L),
    .L1_in0(L1_in0), .L1_in1(L1_in1), .L1_in2(L1_in2), .L1_in3(L1_in3),
    .L1_valid0(L1_valid0), .L1_valid1(L1_valid1),
    .L1_valid2(L1_valid2), .L1_valid3(L1_valid3),
    .data_out(data_out), .valid_out(valid_out), .lane_out(lane_out),
    .fifo_full(fifo_full), .overflow(overflow), .idle(idle)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] e_full();
    logic [3:0] f;
    for (int l = 0; l < 4; l++) f[l] = (mq[l].size() == D);
    return f;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(valid_out), 32'(e_valid));
    check({tag, ".data"}, 32'(data_out), 32'(e_data));
    check({tag, ".lane"}, 32'(lane_out), 32'(e_lane));
    check({tag, ".full"}, 32'(fifo_full), 32'(e_full()));
    check({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
    check({tag, ".idle"}, 32'(idle), 32'(e_idle));
  endtask

  task automatic drive(input logic [3:0] v, input logic [31:0] d);
    {L1_valid3, L1_valid2, L1_valid1, L1_valid0} = v;
    {L1_in3, L1_in2, L1_in1, L1_in0} = d;
  endtask

  task automatic model_reset();
    for (int l = 0; l < 4; l++) mq[l].delete();
    rr_m = 0; e_data = 8'h00; e_valid = 1'b0; e_lane = 2'd0;
    e_ovf = 4'b0000; e_idle = 1'b1;
  endtask

  // One clock edge: pick the first non-empty lane from rr, pop it, then
  // offer each valid byte to its lane (a full lane only has room if popped).
  task automatic model_step(input logic [3:0] v, input logic [31:0] d);
    int g = -1;
    int sz [4];
    bit all_empty;
    for (int l = 0; l < 4; l++) sz[l] = mq[l].size();
    for (int k = 0; k < 4; k++) begin
      int l = (rr_m + k) % 4;
      if (g < 0 && sz[l] > 0) g = l;
    end
    e_valid = (g >= 0);
    if (g >= 0) begin
      e_data = mq[g].pop_front();
      e_lane = 2'(g);
      rr_m   = (g + 1) % 4;
    end
    for (int l = 0; l < 4; l++) begin
      if (v[l]) begin
        if (sz[l] < D || l == g) mq[l].push_back(d[8*l +: 8]);
        else e_ovf[l] = 1'b1;
      end
    end
    all_empty = 1'b1;
    for (int l = 0; l < 4; l++) if (mq[l].size() != 0) all_empty = 1'b0;
    e_idle = all_empty && (v == 4'b0000);
  endtask

  task automatic step(input logic [3:0] v, input logic [31:0] d);
    drive(v, d);
    model_step(v, d);
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  // Entered 1 time unit after a rising edge; asserts reset away from any edge.
  task automatic apply_reset(input bit noisy);
    if (!noisy) drive(4'b0000, 32'h0);
    #2 reset_L = 1'b0;
    model_reset();
    #1 check_all("rst.async");
    repeat (2) begin
      if (noisy) drive(4'($urandom), $urandom);
      @(posedge clk);
      #1 check_all("rst.hold");
    end
    drive(4'b0000, 32'h0);
    @(negedge clk) reset_L = 1'b1;
    #1 check_all("rst.rel");
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 32'h0);
  endtask

  initial begin
    bit seen_full;
    model_reset();
    drive(4'b0000, 32'h0);
    repeat (2) @(posedge clk);
    #1 check_all("por");
    @(negedge clk) reset_L = 1'b1;

    // Single byte on lane 2
    step(4'b0100, 32'h00A5_0000);
    check("a5.nograntyet", 32'(valid_out), 32'd0);
    step(4'b0000, 32'h0);
    check("a5.valid", 32'(valid_out), 32'd1);
    check("a5.data", 32'(data_out), 32'hA5);
    check("a5.lane", 32'(lane_out), 32'd2);
    step(4'b0000, 32'h0);
    check("a5.after.valid", 32'(valid_out), 32'd0);
    check("a5.after.idle", 32'(idle), 32'd1);

    // One byte per lane, drained in lane order from rr=0
    apply_reset(1'b0);
    step(4'b1111, 32'h1312_1110);
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, 32'h0);
      check("seq.valid", 32'(valid_out), 32'd1);
      check("seq.lane", 32'(lane_out), 32'(i));
      check("seq.data", 32'(data_out), 32'(8'h10 + i));
    end
    step(4'b0000, 32'h0);

    // Lanes 0 and 1 streaming: grants alternate 0,1,0,...; on the eighth edge
    // lane 1 is full and not popped, so only the first seven keep overflow clear.
    apply_reset(1'b0);
    for (int i = 1; i <= 8; i++) begin
      step(4'b0011, $urandom);
      if (i >= 2) check("alt.lane", 32'(lane_out), 32'((i - 2) % 2));
      if (i <= 7) check("alt.ovf", 32'(overflow), 32'd0);
    end
    drain(12);

    // All lanes streaming until every lane is full and has dropped bytes
    apply_reset(1'b0);
    seen_full = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(4'b1111, $urandom);
      if (fifo_full == 4'b1111) seen_full = 1'b1;
    end
    check("all.seenfull", 32'(seen_full), 32'd1);
    check("all.ovf", 32'(overflow), 32'hF);
    drain(20);

    // Lane 3 full, granted and written on the same edge
    apply_reset(1'b0);
    for (int i = 0; i < 4; i++) step(4'b1111, $urandom);
    check("l3.full.pre", 32'(fifo_full), 32'b1000);
    step(4'b1000, 32'h5A00_0000);
    check("l3.lane", 32'(lane_out), 32'd3);
    check("l3.full.post", 32'(fifo_full[3]), 32'd1);
    check("l3.ovf", 32'(overflow), 32'd0);
    drain(20);

    // Reset in the middle of a burst with full FIFOs and overflow set
    for (int i = 0; i < 7; i++) step(4'b1111, $urandom);
    apply_reset(1'b1);
    check("mid.valid", 32'(valid_out), 32'd0);
    check("mid.idle", 32'(idle), 32'd1);
    drain(6);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      logic [3:0] v;
      v = 4'($urandom) & 4'($urandom | ((i / 100) % 2 == 0 ? 32'h0 : 32'hF));
      step(v, $urandom);
      if ($urandom_range(0, 199) == 0) apply_reset($urandom_range(0, 1) == 1);
    end
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
